// File: rtl/vga_fb_fetch_arb_if.sv
// rtl/vga_fb_fetch_arb_if.sv - pixel-writer handshake and frame-buffer RAM bus
interface vga_fb_fetch_arb_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      output wr_ready,
      output mem_en,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata
   );

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      input  wr_ready,
      input  mem_en,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/vga_fb_fetch_arb.sv
// rtl/vga_fb_fetch_arb.sv - frame-buffer RAM arbiter: display row fetch into ping-pong line buffer, writer served when idle
module vga_fb_fetch_arb #(
   parameter int FB_W   = 160,
   parameter int FB_H   = 120,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16,
   parameter int COL_W  = 8,
   parameter int ROW_W  = 7
) (
   input  logic              vga_clk,
   input  logic              sys_rst,
   input  logic              line_req,
   input  logic [ROW_W-1:0]  line_idx,
   output logic              fetch_done,
   output logic              lb_we,
   output logic              lb_bank,
   output logic [COL_W-1:0]  lb_addr,
   output logic [DATA_W-1:0] lb_wdata,
   output logic              disp_bank,
   output logic              overrun,
   input  logic              ovr_clr,
   vga_fb_fetch_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   localparam int              ROW_W1   = ROW_W + 1;
   localparam logic [ROW_W:0]  ROW_LIM  = ROW_W1'(FB_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(FB_W - 1);

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] req_base;
   logic              line_ok;
   logic              rd_issue;
   logic              wr_fire;
   logic              wr_pend_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign line_ok  = line_req && ({1'b0, line_idx} < ROW_LIM);
   assign req_base = ADDR_W'(line_idx) * ADDR_W'(FB_W);
   assign rd_issue = (state_q == FETCH);

   // A valid request always (re)starts the row at col 0, whether idle or busy
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      base_d  = base_q;
      if (line_ok) begin
         state_d = FETCH;
         col_d   = '0;
         base_d  = req_base;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (col_q == COL_LAST) state_d = DRAIN;
               else                   col_d   = col_q + 1'b1;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         base_q  <= base_d;
      end
   end

   assign bus.wr_ready = (state_q == IDLE) && !line_req;
   assign wr_fire      = bus.wr_valid && bus.wr_ready;

   // Line-buffer write trails the read by the RAM's one-cycle latency
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         lb_we      <= 1'b0;
         lb_addr    <= '0;
         fetch_done <= 1'b0;
         lb_bank    <= 1'b0;
         disp_bank  <= 1'b1;
         overrun    <= 1'b0;
         wr_pend_q  <= 1'b0;
         wr_addr_q  <= '0;
         wdata_q    <= '0;
      end else begin
         lb_we      <= rd_issue;
         if (rd_issue)
            lb_addr <= col_q;
         fetch_done <= rd_issue && (col_q == COL_LAST) && !line_ok;
         if (fetch_done) begin
            disp_bank <= lb_bank;
            lb_bank   <= ~lb_bank;
         end
         overrun    <= (line_ok && (state_q != IDLE)) || (overrun && !ovr_clr);
         wr_pend_q  <= wr_fire;
         if (wr_fire) begin
            wr_addr_q <= bus.wr_addr;
            wdata_q   <= bus.wr_data;
         end
      end
   end

   // Reads and writes are mutually exclusive by construction of wr_ready
   assign bus.mem_en    = rd_issue || wr_pend_q;
   assign bus.mem_we    = wr_pend_q;
   assign bus.mem_addr  = rd_issue  ? (base_q + ADDR_W'(col_q)) :
                          wr_pend_q ? wr_addr_q : '0;
   assign bus.mem_wdata = wdata_q;
   assign lb_wdata      = bus.mem_rdata;
endmodule
